// File: rtl/alu_seq_if.sv
// Handshake bundle for alu_seq: an operation request channel and a result channel.
// The master side issues operations and consumes results; the ALU is the slave.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   Src1;
    logic [WIDTH-1:0]   Src2;
    logic [SHAMT_W-1:0] Shamt;
    logic [5:0]         Funct;

    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   Result;
    logic [WIDTH-1:0]   Hi;
    logic               Zero;
    logic               Carry;
    logic               Illegal;

    modport master (
        output in_valid, Src1, Src2, Shamt, Funct, out_ready,
        input  in_ready, out_valid, Result, Hi, Zero, Carry, Illegal
    );

    modport slave (
        input  in_valid, Src1, Src2, Shamt, Funct, out_ready,
        output in_ready, out_valid, Result, Hi, Zero, Carry, Illegal
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes: single-cycle ADD/SUB/AND/OR/SLL/SRL
// and an optional shift-add unsigned multiply that retires one multiplier bit per cycle.
module alu_seq #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int CNT_W   = SHAMT_W + 1;

    localparam logic [5:0] F_ADD   = 6'b001001;
    localparam logic [5:0] F_SUB   = 6'b001010;
    localparam logic [5:0] F_AND   = 6'b010001;
    localparam logic [5:0] F_OR    = 6'b010010;
    localparam logic [5:0] F_SLL   = 6'b100001;
    localparam logic [5:0] F_SRL   = 6'b100010;
    localparam logic [5:0] F_MULTU = 6'b011001;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             illegal;
        logic             is_mul;
    } op_t;

    function automatic op_t alu_calc(input logic [5:0]         funct,
                                     input logic [WIDTH-1:0]   a,
                                     input logic [WIDTH-1:0]   b,
                                     input logic [SHAMT_W-1:0] shamt);
        op_t              op;
        logic [WIDTH:0]   sum;
        op  = '0;
        sum = '0;
        case (funct)
            F_ADD: begin
                sum      = {1'b0, a} + {1'b0, b};
                op.res   = sum[WIDTH-1:0];
                op.carry = sum[WIDTH];
            end
            F_SUB: begin
                // Carry out of a + ~b + 1 doubles as the "no borrow" flag
                sum      = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                op.res   = sum[WIDTH-1:0];
                op.carry = sum[WIDTH];
            end
            F_AND:   op.res = a & b;
            F_OR:    op.res = a | b;
            F_SLL:   op.res = b << shamt;
            F_SRL:   op.res = b >> shamt;
            F_MULTU: begin
                op.is_mul  = MUL_EN;
                op.illegal = !MUL_EN;
            end
            default: op.illegal = 1'b1;
        endcase
        return op;
    endfunction

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   acc_hi;

    logic               out_valid_r;
    logic [WIDTH-1:0]   result_r;
    logic [WIDTH-1:0]   hi_r;
    logic               zero_r;
    logic               carry_r;
    logic               illegal_r;

    logic               in_ready_c;
    logic               accept;
    op_t                op_c;
    logic [WIDTH:0]     step_sum;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;

    assign in_ready_c = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign accept     = bus.in_valid && in_ready_c;
    assign op_c       = alu_calc(bus.Funct, bus.Src1, bus.Src2, bus.Shamt);

    // {acc_hi, mplier} shifts right as one register; consumed multiplier bits
    // make room for the low half of the product.
    assign step_sum = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : '0);
    assign step_hi  = step_sum[WIDTH:1];
    assign step_lo  = {step_sum[0], mplier[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            out_valid_r <= 1'b0;
            result_r    <= '0;
            hi_r        <= '0;
            zero_r      <= 1'b0;
            carry_r     <= 1'b0;
            illegal_r   <= 1'b0;
        end else if (accept) begin
            if (op_c.is_mul) begin
                mcand       <= bus.Src1;
                mplier      <= bus.Src2;
                acc_hi      <= '0;
                cnt         <= CNT_W'(WIDTH);
                out_valid_r <= 1'b0;
                state       <= BUSY;
            end else begin
                result_r    <= op_c.res;
                hi_r        <= '0;
                zero_r      <= (op_c.res == '0);
                carry_r     <= op_c.carry;
                illegal_r   <= op_c.illegal;
                out_valid_r <= 1'b1;
                state       <= DONE;
            end
        end else begin
            case (state)
                BUSY: begin
                    acc_hi <= step_hi;
                    mplier <= step_lo;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        result_r    <= step_lo;
                        hi_r        <= step_hi;
                        zero_r      <= ({step_hi, step_lo} == '0);
                        carry_r     <= 1'b0;
                        illegal_r   <= 1'b0;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_r;
    assign bus.Result    = result_r;
    assign bus.Hi        = hi_r;
    assign bus.Zero      = zero_r;
    assign bus.Carry     = carry_r;
    assign bus.Illegal   = illegal_r;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: single-cycle ops, back-to-back issue, iterative multiply,
// reset during multiply, illegal opcodes, and a MUL_EN=0 instance.
module tb_alu_seq;
    localparam logic [5:0] F_ADD   = 6'b001001;
    localparam logic [5:0] F_SUB   = 6'b001010;
    localparam logic [5:0] F_AND   = 6'b010001;
    localparam logic [5:0] F_OR    = 6'b010010;
    localparam logic [5:0] F_SLL   = 6'b100001;
    localparam logic [5:0] F_SRL   = 6'b100010;
    localparam logic [5:0] F_MULTU = 6'b011001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(32)) bus ();
    alu_seq_if #(.WIDTH(32)) bus_nm ();

    alu_seq #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    alu_seq #(.WIDTH(32), .MUL_EN(1'b0)) dut_nm (
        .clk (clk),
        .rst (rst),
        .bus (bus_nm.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        bus.in_valid = 1'b1;
        bus.Funct    = f;
        bus.Src1     = a;
        bus.Src2     = b;
        bus.Shamt    = sh;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int busy_lo;
        int stray;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.Src1 = '0; bus.Src2 = '0; bus.Shamt = '0; bus.Funct = '0;
        bus_nm.in_valid = 1'b0; bus_nm.out_ready = 1'b0;
        bus_nm.Src1 = '0; bus_nm.Src2 = '0; bus_nm.Shamt = '0; bus_nm.Funct = '0;
        step();
        step();
        rst = 1'b0;

        check_val("reset_out_valid", bus.out_valid, 0);
        check_val("reset_result", bus.Result, 0);
        check_val("reset_zero", bus.Zero, 0);
        check_val("reset_in_ready", bus.in_ready, 1);

        // ADD with wrap-around
        bus.out_ready = 1'b1;
        issue(F_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
        step();
        bus.in_valid = 1'b0;
        check_val("add_valid", bus.out_valid, 1);
        check_val("add_result", bus.Result, 0);
        check_val("add_zero", bus.Zero, 1);
        check_val("add_carry", bus.Carry, 1);
        check_val("add_illegal", bus.Illegal, 0);
        check_val("add_hi", bus.Hi, 0);
        step();
        check_val("add_retired", bus.out_valid, 0);

        // SUB back-to-back
        issue(F_SUB, 32'd5, 32'd7, 5'd0);
        check_val("sub1_in_ready", bus.in_ready, 1);
        step();
        check_val("sub1_result", bus.Result, 32'hFFFF_FFFE);
        check_val("sub1_carry", bus.Carry, 0);
        check_val("sub2_in_ready", bus.in_ready, 1);
        issue(F_SUB, 32'd7, 32'd5, 5'd0);
        step();
        check_val("sub2_valid", bus.out_valid, 1);
        check_val("sub2_result", bus.Result, 32'd2);
        check_val("sub2_carry", bus.Carry, 1);

        // Shifts, still back-to-back
        issue(F_SLL, 32'h0, 32'h0000_0001, 5'd31);
        step();
        check_val("sll_result", bus.Result, 32'h8000_0000);
        check_val("sll_zero", bus.Zero, 0);
        issue(F_SRL, 32'h0, 32'h0000_0001, 5'd31);
        step();
        check_val("srl_result", bus.Result, 32'h0);
        check_val("srl_zero", bus.Zero, 1);
        issue(F_SLL, 32'h0, 32'hA5A5_0001, 5'd0);
        step();
        check_val("sll0_result", bus.Result, 32'hA5A5_0001);
        bus.in_valid = 1'b0;
        step();

        // Maximal MULTU; operands change after accept and must be ignored
        bus.out_ready = 1'b0;
        issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        step();
        bus.in_valid = 1'b0;
        bus.Src1 = '0;
        bus.Src2 = '0;
        n = 0;
        busy_lo = 0;
        while (!bus.out_valid && n < 100) begin
            if (!bus.in_ready) busy_lo++;
            step();
            n++;
        end
        check_val("mul_latency", n, 32);
        check_val("mul_busy_cycles", busy_lo, 32);
        check_val("mul_hi", bus.Hi, 32'hFFFF_FFFE);
        check_val("mul_lo", bus.Result, 32'h0000_0001);
        check_val("mul_zero", bus.Zero, 0);
        check_val("mul_carry", bus.Carry, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("mul_hold_valid", bus.out_valid, 1);
            check_val("mul_hold_hi", bus.Hi, 32'hFFFF_FFFE);
            check_val("mul_hold_lo", bus.Result, 32'h0000_0001);
        end
        bus.out_ready = 1'b1;
        step();
        check_val("mul_retired", bus.out_valid, 0);

        // Reset in the middle of a multiply
        bus.out_ready = 1'b0;
        issue(F_MULTU, 32'h0000_1234, 32'h0000_0010, 5'd0);
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("rstmul_valid", bus.out_valid, 0);
        check_val("rstmul_in_ready", bus.in_ready, 1);
        check_val("rstmul_result", bus.Result, 0);
        check_val("rstmul_hi", bus.Hi, 0);
        check_val("rstmul_zero", bus.Zero, 0);
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) stray++;
            step();
        end
        check_val("rstmul_no_late_valid", stray, 0);

        // Small MULTU end to end
        bus.out_ready = 1'b1;
        issue(F_MULTU, 32'h0000_1234, 32'h0000_0010, 5'd0);
        step();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            step();
            n++;
        end
        check_val("mul2_latency", n, 32);
        check_val("mul2_lo", bus.Result, 32'h0001_2340);
        check_val("mul2_hi", bus.Hi, 0);
        step();

        // Illegal opcode followed back-to-back by AND / OR
        issue(6'b000000, 32'h0000_DEAD, 32'h0000_BEEF, 5'd3);
        step();
        check_val("ill_valid", bus.out_valid, 1);
        check_val("ill_flag", bus.Illegal, 1);
        check_val("ill_zero", bus.Zero, 1);
        check_val("ill_result", bus.Result, 0);
        check_val("ill_carry", bus.Carry, 0);
        issue(F_AND, 32'h0000_F0F0, 32'h0000_FF00, 5'd0);
        step();
        check_val("and_result", bus.Result, 32'h0000_F000);
        check_val("and_illegal", bus.Illegal, 0);
        issue(F_OR, 32'h0000_F0F0, 32'h0000_FF00, 5'd0);
        step();
        check_val("or_result", bus.Result, 32'h0000_FFF0);
        bus.in_valid = 1'b0;
        step();

        // MULTU on the instance without a multiplier
        bus_nm.out_ready = 1'b1;
        bus_nm.in_valid  = 1'b1;
        bus_nm.Funct     = F_MULTU;
        bus_nm.Src1      = 32'd3;
        bus_nm.Src2      = 32'd5;
        step();
        bus_nm.in_valid = 1'b0;
        check_val("nm_valid", bus_nm.out_valid, 1);
        check_val("nm_illegal", bus_nm.Illegal, 1);
        check_val("nm_result", bus_nm.Result, 0);
        check_val("nm_hi", bus_nm.Hi, 0);
        check_val("nm_zero", bus_nm.Zero, 1);
        step();
        check_val("nm_retired", bus_nm.out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
